// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the
// arbiter state encoding used on the RX side.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_SEND = 1'b1
  } arb_state_t;

endpackage

// File: rtl/uart_rx_channel_arbiter_if.sv
// Valid/ready byte stream tagged with its
// source channel index.
interface uart_rx_channel_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int CH_W   = 2
);

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CH_W-1:0]   out_ch;

  modport master (
    output out_valid,
    output out_data,
    output out_ch,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_ch,
    output out_ready
  );

endinterface

// File: rtl/uart_rx_channel_arbiter_rr_pick.sv
// Combinational round-robin picker: first set
// request at or after ptr+1, wrapping.
module rr_pick #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              any_req
);

  logic found;
  int   idx;

  // Scan NUM_CH slots starting after ptr; first hit wins.
  always_comb begin
    gnt_idx = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(ptr) + 1 + i) % NUM_CH;
      if (!found && req[CH_W'(idx)]) begin
        found   = 1'b1;
        gnt_idx = CH_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_rx_channel_arbiter.sv
// Per-channel UART RX holding registers merged onto one
// valid/ready stream by a round-robin scheduler.
module uart_rx_channel_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = UART_DATA_W,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        rx_ready_in,
  input  logic [NUM_CH*DATA_W-1:0] rx_data_in,
  uart_rx_channel_arbiter_if.master out_if,
  output logic [NUM_CH-1:0]        overrun,
  input  logic                     overrun_clr
);

  arb_state_t state;
  arb_state_t state_nxt;

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] pending_nxt;
  logic [NUM_CH-1:0] overrun_nxt;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] take;
  logic [NUM_CH-1:0] drop;
  logic [DATA_W-1:0] hold [NUM_CH];

  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   pick;
  logic              any_req;
  logic              load;

  logic [DATA_W-1:0] data_q;
  logic [CH_W-1:0]   ch_q;

  rr_pick #(
    .NUM_CH (NUM_CH)
  ) u_pick (
    .req     (pending),
    .ptr     (rr_ptr),
    .gnt_idx (pick),
    .any_req (any_req)
  );

  // Next state and load decision; a load happens only
  // when something is pending, so pick is always valid.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (any_req) begin
          load      = 1'b1;
          state_nxt = ARB_SEND;
        end
      end
      ARB_SEND: begin
        if (out_if.out_ready) begin
          if (any_req) begin
            load = 1'b1;
          end else begin
            state_nxt = ARB_IDLE;
          end
        end
      end
    endcase
  end

  // Capture vs drop per channel; a slot being granted
  // this cycle frees up for the incoming byte.
  always_comb begin
    grant = '0;
    if (load) begin
      grant[pick] = 1'b1;
    end
    take        = rx_ready_in & (~pending | grant);
    drop        = rx_ready_in & pending & ~grant;
    pending_nxt = (pending & ~grant) | rx_ready_in;
    overrun_nxt = drop | (overrun & ~{NUM_CH{overrun_clr}});
  end

  // Control state, pointer and output registers.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state   <= ARB_IDLE;
      pending <= '0;
      overrun <= '0;
      rr_ptr  <= CH_W'(NUM_CH - 1);
      data_q  <= '0;
      ch_q    <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      overrun <= overrun_nxt;
      if (load) begin
        rr_ptr <= pick;
        data_q <= hold[pick];
        ch_q   <= pick;
      end
    end
  end

  // Per-channel holding registers.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        hold[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (take[k]) begin
          hold[k] <= rx_data_in[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign out_if.out_valid = (state == ARB_SEND);
  assign out_if.out_data  = data_q;
  assign out_if.out_ch    = ch_q;

endmodule
